mem_line_loader: RTL and testbench

- Write-side companion to the wide-line URAM/ROM tables in the Pigasus SME accelerator.
- Accepts a stream of narrow DWIDTH words and packs RATIO = LWIDTH/DWIDTH consecutive words into one LWIDTH line.
- Issues full-line writes on a single memory write port, in the wr_en/address/wr_data form expected by uram_2rw_reg.
- Used by the host/control path to load rule tables before matching starts.

---
 rtl/mem_loader_pkg.sv | 26 ++
 rtl/mem_line_assembler.sv | 59 +++++
 rtl/mem_line_loader.sv | 164 ++++++++++++++++
 tb/tb_mem_line_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the wide-line memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of address bits that select a narrow word within one line.
    function automatic int sel_bits(input int dwidth, input int lwidth);
        return $clog2(lwidth / dwidth);
    endfunction

    // True when the line holds a whole power-of-2 number of narrow words.
    function automatic bit ratio_ok(input int dwidth, input int lwidth);
        int r;
        if (dwidth <= 0 || lwidth < dwidth || (lwidth % dwidth) != 0) return 1'b0;
        r = lwidth / dwidth;
        return ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_line_assembler.sv
// Packs consecutive narrow words into one line buffer and flags line completion.
// Latency: line/complete are combinational with the accepted word; buffer updates on the same edge.
// Backpressure: none here; the parent gates accept with its own ready.
module mem_line_assembler
    import mem_loader_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 64
) (
    input  logic                                clock,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                accept,
    input  logic                                last,
    input  logic [DWIDTH-1:0]                   data,
    output logic [LWIDTH-1:0]                   line,
    output logic                                complete,
    output logic [sel_bits(DWIDTH, LWIDTH):0]   count
);

    localparam int RATIO    = LWIDTH / DWIDTH;
    localparam int SEL_BITS = sel_bits(DWIDTH, LWIDTH);
    localparam int SLOT_W   = (SEL_BITS == 0) ? 1 : SEL_BITS;
    localparam int CNT_W    = SEL_BITS + 1;

    logic [SLOT_W-1:0] slot;
    logic [LWIDTH-1:0] buffer;
    logic [LWIDTH-1:0] buf_next;

    // Buffer contents with the incoming word dropped into the current slot.
    always_comb begin
        buf_next = buffer;
        buf_next[int'(slot) * DWIDTH +: DWIDTH] = data;
    end

    assign line     = buf_next;
    assign complete = accept && (last || (slot == SLOT_W'(RATIO - 1)));
    assign count    = CNT_W'(slot) + CNT_W'(1);

    // Slot counter and buffer: a completed line leaves a clean buffer for the next word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= '0;
            buffer <= '0;
        end else if (clear) begin
            slot   <= '0;
            buffer <= '0;
        end else if (accept) begin
            if (complete) begin
                slot   <= '0;
                buffer <= '0;
            end else begin
                slot   <= slot + SLOT_W'(1);
                buffer <= buf_next;
            end
        end
    end

endmodule

// File: rtl/mem_line_loader.sv
// Packs a narrow word stream into full-line writes on one memory write port.
// Latency: line write issued the cycle after its last word; done pulses one cycle after the final write.
// Backpressure: s_ready is high throughout LOAD/DRAIN (1 word/cycle); optional MEM_LINE_LOADER_CKSUM_EN adds an XOR checksum.
module mem_line_loader
    import mem_loader_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [AWIDTH-1:0] mem_address,
    output logic [LWIDTH-1:0] mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH:0]   words_written,
    output logic [DWIDTH-1:0] cksum
);

    localparam int SEL_BITS = sel_bits(DWIDTH, LWIDTH);
    localparam int LA_W     = AWIDTH - SEL_BITS;
    localparam int WW_W     = AWIDTH + 1;

    if (!ratio_ok(DWIDTH, LWIDTH)) begin : g_bad_ratio
        $error("mem_line_loader: LWIDTH/DWIDTH must be a power of 2");
    end

    state_t              state;
    state_t              next_state;
    logic                load_start;
    logic                word_acc;
    logic                ovf;
    logic [LA_W-1:0]     line_addr;
    logic                wrapped;
    logic [LWIDTH-1:0]   line;
    logic                line_complete;
    logic [SEL_BITS:0]   line_count;

    mem_line_assembler #(
        .DWIDTH (DWIDTH),
        .LWIDTH (LWIDTH)
    ) u_asm (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (load_start),
        .accept   (word_acc),
        .last     (s_last),
        .data     (s_data),
        .line     (line),
        .complete (line_complete),
        .count    (line_count)
    );

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state, stream ready and per-cycle control strobes.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        load_start = 1'b0;
        word_acc   = 1'b0;
        ovf        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (wrapped) begin
                        // The top line is already written: this word has nowhere to go.
                        ovf        = 1'b1;
                        next_state = s_last ? DONE : DRAIN;
                    end else begin
                        word_acc = 1'b1;
                        if (s_last) next_state = DONE;
                    end
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Write port, address counter, progress counters and status flags.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_en        <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_address   <= '0;
            mem_wr_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
            line_addr     <= '0;
            wrapped       <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            if (load_start) begin
                line_addr     <= base_addr[AWIDTH-1:SEL_BITS];
                err           <= 1'b0;
                words_written <= '0;
                busy          <= 1'b1;
                wrapped       <= 1'b0;
            end
            if (word_acc && line_complete) begin
                mem_en        <= 1'b1;
                mem_wr_en     <= 1'b1;
                mem_address   <= AWIDTH'(line_addr) << SEL_BITS;
                mem_wr_data   <= line;
                words_written <= words_written + WW_W'(line_count);
                line_addr     <= line_addr + LA_W'(1);
                if (&line_addr) wrapped <= 1'b1;
            end
            if (ovf) err <= 1'b1;
            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

`ifdef MEM_LINE_LOADER_CKSUM_EN
    logic [DWIDTH-1:0] cksum_q;

    // XOR of every word taken in LOAD, restarted with each load.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                 cksum_q <= '0;
        else if (load_start)        cksum_q <= '0;
        else if (word_acc || ovf)   cksum_q <= cksum_q ^ s_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_mem_line_loader.sv
// Scoreboard bench for mem_line_loader with DWIDTH=8, LWIDTH=32, AWIDTH=8.
// Latency: stimulus pushes expected writes/completions; monitor pops on mem_en and done.
// Backpressure: stimulus waits on s_ready with a bounded cycle budget.
module tb_mem_line_loader;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        mem_en;
    logic        mem_wr_en;
    logic [7:0]  mem_address;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_written;
    logic [7:0]  cksum;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [8:0] ww;
        logic       err;
        logic [7:0] ck;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];

    mem_line_loader #(
        .DWIDTH (8),
        .AWIDTH (8),
        .LWIDTH (32)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .mem_en        (mem_en),
        .mem_wr_en     (mem_wr_en),
        .mem_address   (mem_address),
        .mem_wr_data   (mem_wr_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written),
        .cksum         (cksum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a write or a completion.
    always @(negedge clock) begin
        if (rst_n) begin
            if (mem_en || mem_wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {mem_wr_en, mem_address, mem_wr_data}, 64'h0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write", {mem_en, mem_wr_en, mem_address, mem_wr_data},
                        {1'b1, 1'b1, e.addr, e.data});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'h1, 64'h0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_status", {busy, err, words_written, cksum},
                        {1'b0, d.err, d.ww, d.ck});
                end
            end
        end
    end

    task automatic pulse_start(input logic [7:0] base);
        base_addr = base;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
    endtask

    // Present one word after an optional idle gap and hold it until accepted.
    task automatic send(input logic [7:0] d, input bit l, input int gap);
        int n;
        repeat (gap) begin @(posedge clock); #1; end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        @(negedge clock);
        while (!s_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!s_ready) chk("ready_timeout", 64'h0, 64'h1);
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clock);
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", {63'h0, done}, 64'h1);
        @(posedge clock); #1;
    endtask

    function automatic logic [7:0] ck(input logic [7:0] v);
`ifdef MEM_LINE_LOADER_CKSUM_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        // Reset state.
        #2;
        chk("reset_state", {s_ready, mem_en, mem_wr_en, mem_address, mem_wr_data, busy, done, err},
            64'h0);
        chk("reset_counts", {words_written, cksum}, 64'h0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Scenario 1: one full line, back-to-back.
        wq.push_back('{addr: 8'h10, data: 32'h44332211});
        dq.push_back('{ww: 9'd4, err: 1'b0, ck: ck(8'h44)});
        pulse_start(8'h10);
        chk("busy_after_start", {63'h0, busy}, 64'h1);
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 0);
        send(8'h44, 1, 0);
        @(negedge clock);
        chk("write_cycle_after_last", {mem_en, done}, 64'h2);
        @(negedge clock);
        chk("done_one_cycle_later", {mem_en, done}, 64'h1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("done_one_shot", {done, busy}, 64'h0);
        @(posedge clock); #1;

        // Scenario 2: six words, partial second line zero-filled.
        wq.push_back('{addr: 8'h00, data: 32'h04030201});
        wq.push_back('{addr: 8'h04, data: 32'h00000605});
        dq.push_back('{ww: 9'd6, err: 1'b0, ck: ck(8'h07)});
        pulse_start(8'h00);
        for (int i = 1; i <= 6; i++) send(8'(i), (i == 6), 0);
        wait_done();

        // Scenario 3: unaligned base at the top of memory overflows.
        wq.push_back('{addr: 8'hFC, data: 32'h04030201});
        dq.push_back('{ww: 9'd4, err: 1'b1, ck: ck(8'h01)});
        pulse_start(8'hFE);
        for (int i = 1; i <= 4; i++) send(8'(i), 0, 0);
        @(negedge clock);
        chk("err_before_overflow", {63'h0, err}, 64'h0);
        @(posedge clock); #1;
        send(8'h05, 0, 0);
        @(negedge clock);
        chk("err_on_overflow", {63'h0, err}, 64'h1);
        @(posedge clock); #1;
        send(8'h06, 0, 0);
        send(8'h07, 0, 0);
        send(8'h08, 1, 0);
        wait_done();

        // Scenario 4: gaps in s_valid and an ignored mid-load start.
        wq.push_back('{addr: 8'h10, data: 32'h44332211});
        dq.push_back('{ww: 9'd4, err: 1'b0, ck: ck(8'h44)});
        pulse_start(8'h10);
        send(8'h11, 0, int'($urandom_range(0, 3)));
        send(8'h22, 0, int'($urandom_range(0, 3)));
        base_addr = 8'h80;
        start     = 1'b1;
        send(8'h33, 0, 0);
        start     = 1'b0;
        send(8'h44, 1, int'($urandom_range(0, 3)));
        wait_done();

        // Scenario 5: reset mid-load, then a clean load.
        pulse_start(8'h40);
        send(8'hAA, 0, 0);
        send(8'hBB, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midload_reset_outputs",
            {s_ready, mem_en, mem_wr_en, mem_address, mem_wr_data, busy, done, err}, 64'h0);
        chk("midload_reset_counts", {words_written, cksum}, 64'h0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;
        wq.push_back('{addr: 8'h20, data: 32'hD4C3B2A1});
        dq.push_back('{ww: 9'd4, err: 1'b0, ck: ck(8'h04)});
        pulse_start(8'h20);
        send(8'hA1, 0, 0);
        send(8'hB2, 0, 0);
        send(8'hC3, 0, 0);
        send(8'hD4, 1, 0);
        wait_done();

        repeat (3) @(posedge clock);
        #1;
        chk("writes_consumed", 64'(wq.size()), 64'h0);
        chk("dones_consumed", 64'(dq.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
